// File: rtl/bcd_counter_chain.sv
// Cascaded multi-digit BCD counter with per-digit moduli, up/down stepping,
// saturating load, chain-wrap carry pulse and a lap-freeze display path.
module bcd_counter_chain #(
  parameter int unsigned DIGITS = 4,
  parameter logic [31:0] MODS   = 32'h0000_6A6A
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_en,
  input  logic                  i_up,
  input  logic                  i_clear,
  input  logic                  i_load,
  input  logic [4*DIGITS-1:0]   i_load_val,
  input  logic                  i_lap,
  output logic [4*DIGITS-1:0]   o_count,
  output logic [4*DIGITS-1:0]   o_disp,
  output logic                  o_lap_active,
  output logic                  o_carry
);

  localparam int unsigned W = 4 * DIGITS;

  logic [W-1:0] r_count;
  logic [W-1:0] r_lap_reg;
  logic         r_lap_active;
  logic         r_carry;

  logic [W-1:0] w_count_step;
  logic [W-1:0] w_load_sat;
  logic [3:0]   w_mod;
  logic [3:0]   w_max;
  logic [3:0]   w_dig;
  logic [3:0]   w_ld;
  logic         w_up_ok;
  logic         w_dn_ok;
  logic         w_wrap;

  // Ripple the step-enable upward: after digit i is processed, w_up_ok/w_dn_ok
  // say whether digits 0..i are all at max/zero, which gates digit i+1.
  always_comb begin
    w_count_step = r_count;
    w_load_sat   = '0;
    w_mod        = 4'd0;
    w_max        = 4'd0;
    w_dig        = 4'd0;
    w_ld         = 4'd0;
    w_up_ok      = 1'b1;
    w_dn_ok      = 1'b1;
    for (int i = 0; i < int'(DIGITS); i++) begin
      w_mod = MODS[4*i +: 4];
      w_max = w_mod - 4'd1;
      w_dig = r_count[4*i +: 4];
      w_ld  = i_load_val[4*i +: 4];
      if (i_up) begin
        if (w_up_ok) begin
          w_count_step[4*i +: 4] = (w_dig == w_max) ? 4'd0 : w_dig + 4'd1;
        end
      end else if (w_dn_ok) begin
        w_count_step[4*i +: 4] = (w_dig == 4'd0) ? w_max : w_dig - 4'd1;
      end
      w_up_ok = w_up_ok & (w_dig == w_max);
      w_dn_ok = w_dn_ok & (w_dig == 4'd0);
      w_load_sat[4*i +: 4] = (w_ld >= w_mod) ? w_max : w_ld;
    end
    w_wrap = i_up ? w_up_ok : w_dn_ok;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset || i_clear) begin
      r_count      <= '0;
      r_carry      <= 1'b0;
      r_lap_reg    <= '0;
      r_lap_active <= 1'b0;
    end else begin
      if (i_load) begin
        r_count <= w_load_sat;
        r_carry <= 1'b0;
      end else if (i_en) begin
        r_count <= w_count_step;
        r_carry <= w_wrap;
      end else begin
        r_carry <= 1'b0;
      end
      // Lap snapshots the pre-update count, so it composes with load/en.
      if (i_lap) begin
        if (!r_lap_active) begin
          r_lap_reg    <= r_count;
          r_lap_active <= 1'b1;
        end else begin
          r_lap_active <= 1'b0;
        end
      end
    end
  end

  assign o_count      = r_count;
  assign o_disp       = r_lap_active ? r_lap_reg : r_count;
  assign o_lap_active = r_lap_active;
  assign o_carry      = r_carry;

endmodule

// File: tb/tb_bcd_counter_chain.sv
// Scoreboard bench: the driver pushes expected outputs from a mixed-radix
// integer model; a monitor pops and compares after every clock edge.
module tb_bcd_counter_chain;

  localparam int unsigned DIGITS = 4;
  localparam logic [31:0] MODS   = 32'h0000_6A6A;
  localparam int unsigned W      = 4 * DIGITS;

  typedef struct {
    logic [W-1:0] count;
    logic [W-1:0] disp;
    logic         lap_active;
    logic         carry;
    string        tag;
  } exp_t;

  logic         clk;
  logic         reset, en, up, clear, load, lap;
  logic [W-1:0] load_val;
  logic [W-1:0] count, disp;
  logic         lap_active, carry;

  exp_t q[$];
  int   n_cmp;
  int   n_err;

  // Model state: count as a plain integer in 0..total-1.
  int           m_val;
  int           m_total;
  logic [W-1:0] m_lap_reg;
  logic         m_lap_act;

  bcd_counter_chain #(
    .DIGITS(DIGITS),
    .MODS  (MODS)
  ) dut (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_en        (en),
    .i_up        (up),
    .i_clear     (clear),
    .i_load      (load),
    .i_load_val  (load_val),
    .i_lap       (lap),
    .o_count     (count),
    .o_disp      (disp),
    .o_lap_active(lap_active),
    .o_carry     (carry)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int mod_of(input int i);
    logic [31:0] mv;
    mv = MODS;
    return int'(mv[4*i +: 4]);
  endfunction

  function automatic logic [W-1:0] to_bcd(input int v);
    logic [W-1:0] b;
    int           r;
    b = '0;
    r = v;
    for (int i = 0; i < int'(DIGITS); i++) begin
      b[4*i +: 4] = 4'(r % mod_of(i));
      r = r / mod_of(i);
    end
    return b;
  endfunction

  function automatic int from_bcd_sat(input logic [W-1:0] b);
    int v, wgt, d;
    v   = 0;
    wgt = 1;
    for (int i = 0; i < int'(DIGITS); i++) begin
      d = int'(b[4*i +: 4]);
      if (d > mod_of(i) - 1) d = mod_of(i) - 1;
      v   = v + d * wgt;
      wgt = wgt * mod_of(i);
    end
    return v;
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // One clock of stimulus: drive inputs, advance the model, push expectation.
  task automatic cycle(input logic i_rst, input logic i_clr, input logic i_ld,
                       input logic [W-1:0] i_lv, input logic i_e, input logic i_u,
                       input logic i_lp, input string tag);
    exp_t         e;
    logic [W-1:0] prev;
    logic         c;
    reset = i_rst; clear = i_clr; load = i_ld; load_val = i_lv;
    en = i_e; up = i_u; lap = i_lp;
    c = 1'b0;
    if (i_rst || i_clr) begin
      m_val = 0; m_lap_reg = '0; m_lap_act = 1'b0;
    end else begin
      prev = to_bcd(m_val);
      if (i_ld) begin
        m_val = from_bcd_sat(i_lv);
      end else if (i_e) begin
        if (i_u) begin
          c     = (m_val == m_total - 1);
          m_val = (m_val + 1) % m_total;
        end else begin
          c     = (m_val == 0);
          m_val = (m_val + m_total - 1) % m_total;
        end
      end
      if (i_lp) begin
        if (!m_lap_act) begin
          m_lap_reg = prev;
          m_lap_act = 1'b1;
        end else begin
          m_lap_act = 1'b0;
        end
      end
    end
    e.count      = to_bcd(m_val);
    e.disp       = m_lap_act ? m_lap_reg : e.count;
    e.lap_active = m_lap_act;
    e.carry      = c;
    e.tag        = tag;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        check({e.tag, ".count"}, count, e.count);
        check({e.tag, ".disp"}, disp, e.disp);
        check({e.tag, ".lap_active"}, W'(lap_active), W'(e.lap_active));
        check({e.tag, ".carry"}, W'(carry), W'(e.carry));
      end
    end
  end

  initial begin : driver
    logic [W-1:0] lv;
    int           budget;
    n_cmp = 0; n_err = 0;
    m_val = 0; m_lap_reg = '0; m_lap_act = 1'b0;
    m_total = 1;
    for (int i = 0; i < int'(DIGITS); i++) m_total = m_total * mod_of(i);

    cycle(1, 0, 0, '0, 1, 1, 0, "reset0");
    cycle(1, 0, 0, '0, 1, 1, 0, "reset1");

    cycle(0, 0, 1, 16'h0959, 0, 1, 0, "ld0959");
    cycle(0, 0, 0, '0, 1, 1, 0, "up_cascade");
    cycle(0, 0, 1, 16'h5959, 0, 1, 0, "ld5959");
    cycle(0, 0, 0, '0, 1, 1, 0, "up_wrap");
    cycle(0, 0, 0, '0, 0, 1, 0, "carry_drop");
    cycle(0, 0, 0, '0, 1, 0, 0, "down_borrow");
    cycle(0, 0, 0, '0, 1, 0, 0, "down_next");
    cycle(0, 0, 1, 16'hFFFF, 1, 1, 0, "ld_sat");
    cycle(0, 0, 1, 16'hC9C9, 0, 1, 0, "ld_sat_mix");
    cycle(0, 1, 1, 16'h1234, 1, 1, 1, "ld_clear");

    cycle(0, 0, 1, 16'h0012, 0, 1, 0, "ld0012");
    cycle(0, 0, 0, '0, 1, 1, 1, "lap_on");
    for (int k = 0; k < 4; k++) cycle(0, 0, 0, '0, 1, 1, 0, "lap_hold");
    cycle(0, 0, 0, '0, 1, 1, 1, "lap_off");
    cycle(0, 0, 0, '0, 1, 1, 0, "lap_after");
    cycle(0, 0, 0, '0, 1, 1, 1, "lap_on2");
    cycle(0, 0, 1, 16'h3333, 1, 1, 1, "lap_load");
    cycle(0, 0, 0, '0, 1, 1, 1, "lap_rearm");
    cycle(1, 0, 0, '0, 1, 1, 1, "lap_reset");

    for (int k = 0; k < 600; k++) begin
      lv = W'($urandom);
      if ($urandom_range(0, 3) == 0) lv = ($urandom_range(0, 1) == 0) ? 16'h5959 : 16'h0000;
      cycle(($urandom_range(0, 63) == 0), ($urandom_range(0, 39) == 0),
            ($urandom_range(0, 9) == 0), lv, ($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 1)), ($urandom_range(0, 11) == 0), "rand");
    end

    budget = 10;
    while (q.size() > 0 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    #3;
    n_cmp++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending, expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/bcd_counter_chain.md
# bcd_counter_chain

Parametrised, cascaded multi-digit BCD counter for the stopwatch datapath; the next generation of the single-decade counter. Each digit has its own modulus, so the default configuration counts a full mm:ss display, 00:00 to 59:59. The block adds up/down counting, synchronous load, clear, a chain-wrap carry pulse and a lap-freeze display path. It sits between the tick divider and the 7-segment scan driver.

## Interface
- DIGITS, 4, number of BCD digits (1..8).
- MODS, 32'h0000_6A6A, packed per-digit moduli, 4 bits per digit, digit 0 in bits [3:0]. Legal range per digit is 2..10. Default: sec-units 10, sec-tens 6, min-units 10, min-tens 6.
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- en  in  1  count tick; one step per cycle while high.
- up  in  1  1 = count up, 0 = count down; sampled only when en is high.
- clear  in  1  synchronous clear of count and lap state.
- load  in  1  synchronous load of load_val.
- load_val  in  4*DIGITS  packed BCD value to load.
- lap  in  1  single-cycle pulse; toggles the lap freeze.
- count  out  4*DIGITS  live counter value, registered.
- disp  out  4*DIGITS  display value: the frozen lap value while lap_active, otherwise count.
- lap_active  out  1  high while the display is frozen.
- carry  out  1  registered one-cycle pulse on full-chain wrap.

## Operation
- Priority per edge, highest first: reset > clear > load > en.
- reset: count=0, lap_reg=0, lap_active=0, carry=0.
- clear: same effect as reset on all outputs.
- load: count<=load_val, carry<=0.
  - Any digit ≥ its modulus is saturated to modulus-1, e.g. 4'hC into a mod-6 digit loads 5.
  - Applies per digit.
- en counting up:
  - Digit 0 always steps.
  - Digit i steps only if every lower digit equals its modulus-1.
  - A stepping digit at modulus-1 goes to 0; otherwise it goes to +1.
- en counting down:
  - Digit i steps only if every lower digit is 0.
  - A stepping digit at 0 goes to modulus-1; otherwise it goes to -1.
- carry:
  - Set to 1 for exactly the cycle after an up-step from all-max to all-zero.
  - Set to 1 for exactly the cycle after a down-step from all-zero to all-max.
  - 0 in every other cycle.
- en low: count holds and carry=0.
- lap, when lap_active=0: lap_reg<=count (the pre-update value at that edge) and lap_active<=1. Counting continues in the same cycle.
- lap, when lap_active=1: lap_active<=0; disp follows count from the next cycle.
- lap together with clear or reset: clear/reset wins and lap_active=0.
- lap together with load: both take effect; lap_reg captures the pre-load count.
- disp is combinational: lap_active ? lap_reg : count.

## Timing
- count latency: 1 clock from a sampled en/load/clear to the new count.
- carry latency: asserted in the same cycle count shows the wrapped value.
- disp: zero added latency beyond the lap_active/lap_reg registers.
- No handshake; en may be held high continuously, giving one step per clock.
- Reset mid-count takes effect at the next edge regardless of en, load or lap.
- Reset behaviour is fixed: synchronous and active-high. No asynchronous path exists.

## Test plan
- Reset: reset=1 for 2 cycles with en=1 -> count=0x0000, disp=0x0000, carry=0, lap_active=0.
- Up cascade: load 0x0959, then 1 cycle of en=1, up=1 -> count=0x1000, carry=0.
- Up wrap: load 0x5959, then 1 en, up=1 -> count=0x0000 and carry=1 for one cycle only.
- Down borrow: from 0x0000, 1 en with up=0 -> count=0x5959, carry=1. A further 1 en -> 0x5958, carry=0.
- Load saturation: load_val=0xFFFF -> count=0x5959. Simultaneous load=1 and clear=1 -> count=0x0000.
- Lap freeze: at count=0x0012 pulse lap with en held high.
  - Over the next 5 cycles disp stays 0x0012 while count reaches 0x0017.
  - A second lap pulse releases the freeze: disp equals count on the next cycle and lap_active=0.
